// File: rtl/splash_painter_if.sv
// Plot-path bundle between the splash controller, the title/game-over ROMs and the VGA adapter.
// The slave side is the painter; the master side is everything around it.
interface splash_painter_if;
  logic        wren;
  logic        showTitle;
  logic        showGameOver;
  logic        flash;
  logic        drawBlack;
  logic [14:0] rom_addr;
  logic [2:0]  title_q;
  logic [2:0]  gameover_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        frame_done;

  modport master (
    output wren, showTitle, showGameOver, flash, drawBlack, title_q, gameover_q,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, frame_done
  );

  modport slave (
    input  wren, showTitle, showGameOver, flash, drawBlack, title_q, gameover_q,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, frame_done
  );
endinterface

// File: rtl/splash_painter.sv
// Full-screen raster filler: one pixel per cycle while wren is high, two-stage pipeline so the
// synchronous ROM data lines up with the plotted coordinate.
module splash_painter #(
  parameter int         SCR_W     = 160,
  parameter int         SCR_H     = 120,
  parameter logic [2:0] FLASH_COL = 3'b100,
  parameter logic [2:0] BLACK_COL = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  splash_painter_if.slave  bus
);

  typedef enum logic [1:0] {MODE_BLACK, MODE_FLASH, MODE_GAMEOVER, MODE_TITLE} mode_e;

  mode_e       mode_sel, prev_mode, mode1;
  logic        prev_wren, restart, at_row_end, at_last;
  logic [7:0]  x, cur_x, x1;
  logic [6:0]  y, cur_y, y1;
  logic [14:0] addr, cur_addr;
  logic        valid, last1;

  always_comb begin
    // NOTE: default assignment first, so no path through the if-chain can infer a latch.
    mode_sel = MODE_BLACK;
    if      (bus.showTitle)    mode_sel = MODE_TITLE;
    else if (bus.showGameOver) mode_sel = MODE_GAMEOVER;
    else if (bus.flash)        mode_sel = MODE_FLASH;
  end

  // A restart emits pixel 0 in the same cycle, so the live pixel is muxed ahead of the registers.
  assign restart    = bus.wren && (!prev_wren || (mode_sel != prev_mode));
  assign cur_x      = restart ? '0 : x;
  assign cur_y      = restart ? '0 : y;
  assign cur_addr   = restart ? '0 : addr;
  assign at_row_end = (cur_x == 8'(SCR_W - 1));
  assign at_last    = at_row_end && (cur_y == 7'(SCR_H - 1));
  assign bus.rom_addr = cur_addr;

  // NOTE: synchronous active-low reset; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      prev_wren <= 1'b0;
      prev_mode <= MODE_BLACK;
    end else begin
      prev_wren <= bus.wren;
      prev_mode <= mode_sel;
      if (bus.wren) begin
        if (at_last) begin
          x    <= '0;
          y    <= '0;
          addr <= '0;
        end else if (at_row_end) begin
          x    <= '0;
          y    <= cur_y + 7'd1;
          addr <= cur_addr + 15'd1;
        end else begin
          x    <= cur_x + 8'd1;
          addr <= cur_addr + 15'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      mode1 <= MODE_BLACK;
      last1 <= 1'b0;
    end else begin
      valid <= bus.wren;
      x1    <= cur_x;
      y1    <= cur_y;
      mode1 <= mode_sel;
      last1 <= at_last;
    end
  end

  assign bus.vga_plot   = valid;
  assign bus.vga_x      = x1;
  assign bus.vga_y      = y1;
  assign bus.frame_done = valid && last1;

  // ROM data arrives one cycle after rom_addr, i.e. alongside the stage-1 registers.
  always_comb begin
    bus.vga_colour = BLACK_COL;
    case (mode1)
      MODE_TITLE:    bus.vga_colour = bus.title_q;
      MODE_GAMEOVER: bus.vga_colour = bus.gameover_q;
      MODE_FLASH:    bus.vga_colour = FLASH_COL;
      default:       bus.vga_colour = BLACK_COL;
    endcase
  end

endmodule

// File: tb/tb_splash_painter.sv
// Bench for splash_painter: pixel-index reference model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_splash_painter;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;

  splash_painter_if bus ();

  splash_painter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous ROM models: title = addr mod 8, game-over = 7 - (addr mod 8).
  always @(posedge clk) begin
    bus.title_q    <= bus.rom_addr[2:0];
    bus.gameover_q <= ~bus.rom_addr[2:0];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model state: next pixel index, previous request, and the pixel expected on the plot port.
  int k         = 0;
  bit prev_w    = 1'b0;
  int prev_mode = 0;
  bit pend      = 1'b0;
  int pend_k    = 0;
  int pend_mode = 0;
  int plot_count = 0;
  int fd_count   = 0;
  int last_x     = -1;
  int last_y     = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // 3=title, 2=game-over, 1=flash, 0=black
  function automatic int sel_mode();
    if (bus.showTitle)    return 3;
    if (bus.showGameOver) return 2;
    if (bus.flash)        return 1;
    return 0;
  endfunction

  function automatic int exp_colour(input int mode, input int idx);
    case (mode)
      3:       return idx % 8;
      2:       return 7 - (idx % 8);
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  // Compare the plot port against the pending pixel, then account for this cycle's request.
  task automatic compare_and_step();
    int m;
    check("vga_plot", 32'(bus.vga_plot), 32'(pend));
    if (pend) begin
      check("vga_x", 32'(bus.vga_x), pend_k % W);
      check("vga_y", 32'(bus.vga_y), pend_k / W);
      check("vga_colour", 32'(bus.vga_colour), exp_colour(pend_mode, pend_k));
      check("frame_done", 32'(bus.frame_done), 32'(pend_k == N - 1));
      plot_count++;
      if (bus.frame_done) fd_count++;
      last_x = int'(bus.vga_x);
      last_y = int'(bus.vga_y);
    end else begin
      check("frame_done_idle", 32'(bus.frame_done), 0);
    end
    if (!rst) begin
      pend      = 1'b0;
      k         = 0;
      prev_w    = 1'b0;
      prev_mode = 0;
    end else begin
      m = sel_mode();
      if (bus.wren) begin
        if (!prev_w || m != prev_mode) k = 0;
        check("rom_addr", 32'(bus.rom_addr), k);
        pend      = 1'b1;
        pend_k    = k;
        pend_mode = m;
        k         = (k + 1) % N;
      end else begin
        pend = 1'b0;
      end
      prev_w    = bus.wren;
      prev_mode = m;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_and_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_modes(input bit t, input bit g, input bit f, input bit b);
    bus.showTitle    = t;
    bus.showGameOver = g;
    bus.flash        = f;
    bus.drawBlack    = b;
  endtask

  int pc0, fd0;

  initial begin
    bus.wren = 1'b0;
    set_modes(0, 0, 0, 0);

    // Reset, then idle.
    tick(3);
    rst = 1'b1;
    tick(5);
    check("idle_plot", 32'(bus.vga_plot), 0);
    check("idle_rom_addr", 32'(bus.rom_addr), 0);
    check("idle_frame_done", 32'(bus.frame_done), 0);

    // Full black frame.
    pc0 = plot_count;
    fd0 = fd_count;
    set_modes(0, 0, 0, 1);
    bus.wren = 1'b1;
    tick(N);
    bus.wren = 1'b0;
    tick(1);
    check("frame_plots", plot_count - pc0, N);
    check("frame_done_pulses", fd_count - fd0, 1);
    check("frame_last_x", last_x, 159);
    check("frame_last_y", last_y, 119);
    tick(2);

    // Title ROM path and latency.
    set_modes(1, 0, 0, 0);
    bus.wren = 1'b1;
    tick(10);
    check("title_x9", 32'(bus.vga_x), 9);
    check("title_colour9", 32'(bus.vga_colour), 1);
    check("title_rom_addr10", 32'(bus.rom_addr), 10);
    tick(30);
    bus.wren = 1'b0;
    tick(2);

    // Burst, gap, burst; then mid-burst mode switch.
    pc0 = plot_count;
    set_modes(0, 0, 1, 0);
    bus.wren = 1'b1;
    tick(50);
    bus.wren = 1'b0;
    tick(10);
    check("gap_plot", 32'(bus.vga_plot), 0);
    check("burst_plots", plot_count - pc0, 50);
    bus.wren = 1'b1;
    tick(1);
    check("reburst_plot", 32'(bus.vga_plot), 1);
    check("reburst_x", 32'(bus.vga_x), 0);
    check("reburst_y", 32'(bus.vga_y), 0);
    tick(20);
    set_modes(0, 1, 0, 0);
    tick(1);
    check("switch_x", 32'(bus.vga_x), 0);
    check("switch_colour", 32'(bus.vga_colour), 7);
    tick(15);

    // Priority: title wins over flash and black; flash alone gives red.
    set_modes(1, 0, 1, 1);
    tick(5);
    check("prio_x", 32'(bus.vga_x), 4);
    check("prio_colour", 32'(bus.vga_colour), 4);
    set_modes(0, 0, 1, 0);
    tick(6);
    check("flash_x", 32'(bus.vga_x), 5);
    check("flash_colour", 32'(bus.vga_colour), 3'b100);
    bus.wren = 1'b0;
    tick(2);

    // Reset in the middle of a fill.
    set_modes(0, 0, 0, 1);
    bus.wren = 1'b1;
    tick(7000);
    rst = 1'b0;
    tick(1);
    check("rst_plot", 32'(bus.vga_plot), 0);
    rst = 1'b1;
    tick(1);
    check("post_rst_plot", 32'(bus.vga_plot), 1);
    check("post_rst_x", 32'(bus.vga_x), 0);
    check("post_rst_y", 32'(bus.vga_y), 0);
    tick(20);

    // Randomized requests, modes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bus.wren = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        logic [3:0] r;
        r = 4'($urandom_range(0, 15));
        set_modes(r[3], r[2], r[1], r[0]);
      end
      rst = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    rst = 1'b1;
    bus.wren = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
